// File: rtl/parity_frame_rx_if.sv
// Receive-side bundle for the parity frame receiver: serial line in,
// recovered byte and status out.
interface parity_frame_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx,
        input  data,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data,
        output valid,
        output parity_err,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Serial receiver for start + 8 data (LSB first) + even parity + stop frames.
// Recovers the byte, flags parity and framing errors, strobes valid for one cycle.
module parity_frame_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst,
    parity_frame_rx_if.slave bus
);

    localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t            state, state_d;
    logic              rx_m, rx_s, rx_q;
    logic [TICK_W-1:0] tick, tick_d;
    logic [2:0]        bit_cnt, bit_cnt_d;
    logic [7:0]        shift, shift_d;
    logic              perr, perr_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic              tick_full;

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tick         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            perr         <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_d;
            tick         <= tick_d;
            bit_cnt      <= bit_cnt_d;
            shift        <= shift_d;
            perr         <= perr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign tick_full = (tick == TICK_FULL);

    // Tick counter free-runs inside a bit and restarts at every sample point
    always_comb begin
        state_d      = state;
        tick_d       = tick + TICK_W'(1);
        bit_cnt_d    = bit_cnt;
        shift_d      = shift;
        perr_d       = perr;
        data_d       = data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state)
            IDLE: begin
                tick_d = '0;
                if (rx_q && !rx_s) begin
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick == TICK_HALF) begin
                    tick_d  = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_full) begin
                    tick_d           = '0;
                    shift_d[bit_cnt] = rx_s;
                    bit_cnt_d        = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tick_full) begin
                    tick_d  = '0;
                    perr_d  = (^shift) ^ rx_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick_full) begin
                    tick_d       = '0;
                    data_d       = shift;
                    parity_err_d = perr;
                    frame_err_d  = ~rx_s;
                    valid_d      = 1'b1;
                    state_d      = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be mistaken for a new start bit
                tick_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.data       = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;

endmodule
